// File: rtl/lc3b_types.sv
// Shared LC-3b types for the memory responder: data word, byte mask,
// responder FSM states and the port identifier used by the arbiter.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_mask;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPOND
  } lc3b_mem_state;

  typedef enum logic {
    PORT_I,
    PORT_D
  } lc3b_mem_port;

  // Word returned by reads that fall outside the array when bounds checking is built in.
  localparam lc3b_word MEM_OOB_WORD = 16'hDEAD;

  function automatic lc3b_mem_port other_port(input lc3b_mem_port p);
    return (p == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/lc3b_mem_arbiter.sv
// Combinational round-robin arbiter between the instruction and data ports.
// On a conflict the port that was not granted last time wins.
module lc3b_mem_arbiter
  import lc3b_types::*;
(
  input  logic         i_req,
  input  logic         d_req,
  input  lc3b_mem_port last_grant,
  output logic         grant_valid,
  output lc3b_mem_port grant_port
);

  // Pick a single requester; alternate on simultaneous requests.
  always_comb begin
    grant_valid = i_req | d_req;
    grant_port  = PORT_I;
    if (i_req && d_req) begin
      grant_port = other_port(last_grant);
    end else if (d_req) begin
      grant_port = PORT_D;
    end
  end

endmodule

// File: rtl/lc3b_mem_responder.sv
// Dual-port (instruction + data) memory responder backed by one single-ported
// word array with fixed request-to-response latency DELAY.
// Optional build macro: LC3B_MEM_BOUNDS_EN adds the sticky mem_err output and
// rejects accesses above the array instead of wrapping them.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | sample requests, accept one via the arbiter
// BUSY    | latency down-counter running; abort if requester drops
// RESPOND | resp pulse for the granted port, then back to IDLE
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int    DEPTH     = 256,
  parameter int    DELAY     = 4,
  parameter string INIT_FILE = ""
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_mem_read,
  input  lc3b_word     i_mem_address,
  output lc3b_word     i_mem_rdata,
  output logic         i_mem_resp,
  input  logic         d_mem_read,
  input  logic         d_mem_write,
  input  lc3b_mem_mask d_mem_byte_enable,
  input  lc3b_word     d_mem_address,
  input  lc3b_word     d_mem_wdata,
  output lc3b_word     d_mem_rdata,
  output logic         d_mem_resp
`ifdef LC3B_MEM_BOUNDS_EN
  ,
  output logic         mem_err
`endif
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(DELAY - 1);

  lc3b_word mem [DEPTH];

  lc3b_mem_state state_q, state_d;
  logic [3:0]    count_q, count_d;
  lc3b_mem_port  last_grant_q, last_grant_d;
  lc3b_mem_port  port_q, port_d;
  lc3b_word      addr_q, addr_d;
  lc3b_word      wdata_q, wdata_d;
  lc3b_mem_mask  mask_q, mask_d;
  logic          write_q, write_d;
  lc3b_word      i_rdata_q, i_rdata_d;
  lc3b_word      d_rdata_q, d_rdata_d;

  logic          grant_valid;
  lc3b_mem_port  grant_port;
  logic          d_req;
  logic          req_held;
  logic          access;
  logic          mem_we;
  logic          in_range;
  logic [AW-1:0] idx_d;
  lc3b_word      rd_word;

  // Bit 0 is a byte select the word array never needs; upper bits only matter with bounds checking.
  logic          unused_addr_bits;
  assign unused_addr_bits = ^{addr_d[0], addr_d[15:AW+1]};

  // A simultaneous read and write on the data port is a write.
  assign d_req = d_mem_read | d_mem_write;

  lc3b_mem_arbiter u_arbiter (
    .i_req       (i_mem_read),
    .d_req       (d_req),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  assign req_held = (port_q == PORT_I) ? i_mem_read : d_req;
  assign idx_d    = addr_d[AW:1];

`ifdef LC3B_MEM_BOUNDS_EN
  assign in_range = (addr_d[15:AW+1] == '0);
`else
  assign in_range = 1'b1;
`endif

  assign rd_word = in_range ? mem[idx_d] : MEM_OOB_WORD;

  // Next-state, latency counter and capture of the accepted request.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    write_d      = write_q;
    access       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          port_d       = grant_port;
          last_grant_d = grant_port;
          if (grant_port == PORT_I) begin
            addr_d  = i_mem_address;
            wdata_d = '0;
            mask_d  = '0;
            write_d = 1'b0;
          end else begin
            addr_d  = d_mem_address;
            wdata_d = d_mem_wdata;
            mask_d  = d_mem_byte_enable;
            write_d = d_mem_write;
          end
          if (DELAY == 1) begin
            state_d = RESPOND;
            access  = 1'b1;
          end else begin
            state_d = BUSY;
            count_d = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (!req_held) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == 4'd1) begin
          state_d = RESPOND;
          count_d = '0;
          access  = 1'b1;
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Array access on entry to RESPOND: load read data or raise the write strobe.
  always_comb begin
    i_rdata_d = '0;
    d_rdata_d = '0;
    mem_we    = 1'b0;
    if (access) begin
      if (write_d) begin
        mem_we = in_range & ~rst;
      end else if (port_d == PORT_I) begin
        i_rdata_d = rd_word;
      end else begin
        d_rdata_d = rd_word;
      end
    end
  end

  // FSM and request capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      last_grant_q <= PORT_I;
      port_q       <= PORT_I;
      addr_q       <= '0;
      wdata_q      <= '0;
      mask_q       <= '0;
      write_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mask_q       <= mask_d;
      write_q      <= write_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Byte-masked write into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      if (mask_d[0]) mem[idx_d][7:0]  <= wdata_d[7:0];
      if (mask_d[1]) mem[idx_d][15:8] <= wdata_d[15:8];
    end
  end

`ifdef LC3B_MEM_BOUNDS_EN
  logic mem_err_q, mem_err_d;

  assign mem_err_d = mem_err_q | (access & ~in_range);

  // Sticky out-of-range flag, visible from the RESPOND cycle onward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_err_q <= 1'b0;
    else     mem_err_q <= mem_err_d;
  end

  assign mem_err = mem_err_q;
`endif

  assign i_mem_resp  = (state_q == RESPOND) && (port_q == PORT_I);
  assign d_mem_resp  = (state_q == RESPOND) && (port_q == PORT_D);
  assign i_mem_rdata = i_rdata_q;
  assign d_mem_rdata = d_rdata_q;

endmodule
